memory_sp_arb: RTL and testbench
================================

MEMORY_SP_ARB -- requirements
Module: memory_sp_arb

Interface
REQ-001 Parameter DW, default 32, memory data width in bits.
REQ-002 Parameter DEPTH, default 32, memory depth in words.
REQ-003 Parameter N, default 2, number of requesters, range 2..8.
REQ-004 Parameter AW, default $clog2(DEPTH), address width.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 nreset  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  N  per-requester access request.
REQ-008 req_we  in  N  per-requester write (1) / read (0).
REQ-009 req_lock  in  N  hold the grant after this beat (burst).
REQ-010 req_addr  in  N*AW  packed addresses, requester i at [i*AW +: AW].
REQ-011 req_din  in  N*DW  packed write data.
REQ-012 req_wem  in  N*DW  packed write-enable masks.
REQ-013 req_ready  out  N  one-hot accept; a beat transfers when valid&ready.
REQ-014 rsp_valid  out  N  one-hot read-data-valid per requester.
REQ-015 rsp_dout  out  DW  shared read data, qualified by rsp_valid.
REQ-016 mem_en, mem_we  out  1 each  memory access and write enable.
REQ-017 mem_addr  out  AW; mem_din, mem_wem  out  DW each  memory command.
REQ-018 mem_dout  in  DW  memory read data, valid 1 cycle after a read command.

Function
REQ-019 At most one bit of req_ready SHALL be high per cycle, and only for a requester with req_valid high (combinational from req_valid and state).
REQ-020 Arbitration SHALL be round-robin: priority starts at the index after the last granted requester; after reset, requester 0 has highest priority.
REQ-021 A granted beat SHALL drive mem_en=1, mem_we/addr/din/wem from that requester in the same cycle; with no grant, mem_en=0, mem_we=0, mem_wem=0.
REQ-022 A granted read SHALL produce rsp_valid[i]=1 and rsp_dout=mem_dout exactly 1 cycle later; writes produce no response.
REQ-023 Back-to-back reads from any mix of requesters SHALL sustain 1 access per cycle with no bubbles.
REQ-024 FSM states: IDLE (no owner) and LOCKED (owner held); IDLE->LOCKED on a granted beat with req_lock=1; LOCKED->IDLE on an owner beat with req_lock=0, or when the owner deasserts req_valid.
REQ-025 In LOCKED only the owner SHALL receive req_ready; other requesters stall regardless of priority.
REQ-026 The round-robin pointer SHALL update only on a transferred beat, never on idle cycles.
REQ-027 A requester SHALL not be starved: a locked burst SHALL be terminated by the arbiter after 16 consecutive beats (lock counter), returning to IDLE with the pointer advanced past the owner.
REQ-028 Read and write to the same address in consecutive cycles SHALL be passed through in order; no forwarding is performed.

Reset
REQ-029 On nreset low: req_ready=0, rsp_valid=0, rsp_dout=0, mem_en=0, mem_we=0, FSM=IDLE, pointer=N-1 (so requester 0 wins first), lock counter=0.
REQ-030 Reset asserted mid-read SHALL drop the pending response; no rsp_valid after reset release.
REQ-031 Outputs SHALL be glitch-free of stale grants on the first cycle after reset release.

Structure
REQ-032 No package typedefs; read latency (1) and lock limit (16) SHALL be localparams in the shared memory constants file.
REQ-033 Round-robin priority select SHALL be one sub-module, arb_rr (N-bit request in, one-hot grant out, pointer in).
REQ-034 The block SHALL connect directly to a memory_sp instance; no memory is instantiated inside.

Verification
REQ-035 Reset release, req_valid=2'b11 both reads -> cycle 0 grant r0, cycle 1 grant r1; rsp_valid=01 then 10 one cycle after each.
REQ-036 r0 writes 0xDEADBEEF to addr 5, wem all ones; r1 reads addr 5 next cycle -> rsp_dout=0xDEADBEEF, rsp_valid=10.
REQ-037 r0 holds req_lock=1 and valid for 20 beats, r1 valid throughout -> r0 gets 16 beats, then r1 granted, then r0.
REQ-038 r1 lock burst of 3 beats, lock dropped on beat 3 -> r0 granted on next cycle.
REQ-039 nreset asserted the cycle after a granted read -> no rsp_valid, all outputs zero, first post-reset grant to r0.

Source files
------------

// File: rtl/memory_sp_arb_pkg.sv
// Shared memory-port constants: read latency and the burst lock limit used by
// the single-port memory arbiter.
package memory_sp_arb_pkg;

  localparam int RD_LAT     = 1;
  localparam int LOCK_LIMIT = 16;
  localparam int LOCK_CW    = $clog2(LOCK_LIMIT + 1);

endpackage

// File: rtl/memory_sp_arb_arb_rr.sv
// Round-robin priority select: the first requester after ptr (wrapping) wins;
// the grant is one-hot or all zero.
module arb_rr #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_sp_arb.sv
// N-requester front end for a single-port memory: round-robin grants, optional
// locked bursts bounded by LOCK_LIMIT beats, and one-cycle read responses.
module memory_sp_arb
  import memory_sp_arb_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int N     = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_we,
  input  logic [N-1:0]    req_lock,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_din,
  input  logic [N*DW-1:0] req_wem,
  output logic [N-1:0]    req_ready,
  output logic [N-1:0]    rsp_valid,
  output logic [DW-1:0]   rsp_dout,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_din,
  output logic [DW-1:0]   mem_wem,
  input  logic [DW-1:0]   mem_dout
);

  localparam int PW = $clog2(N);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]         state;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      owner;
  logic [PW-1:0]      gnt_idx;
  logic [LOCK_CW-1:0] lock_cnt;
  logic [N-1:0]       arb_req;
  logic [N-1:0]       arb_gnt;
  logic [N-1:0]       gnt;
  logic               fire;
  logic [N-1:0]       rd_pipe [RD_LAT];

  // While a burst is locked only the owner may compete.
  always_comb begin
    arb_req = req_valid;
    if (state == ST_LOCKED) arb_req = req_valid & (N'(1) << owner);
  end

  arb_rr #(.N(N), .PW(PW)) u_arb (
    .req(arb_req),
    .ptr(ptr),
    .gnt(arb_gnt)
  );

  // Gating with nreset keeps stale grants off the bus while reset is held.
  assign gnt       = nreset ? arb_gnt : '0;
  assign req_ready = gnt;
  assign fire      = |gnt;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_idx = PW'(i);
    end
  end

  always_comb begin
    mem_en   = fire;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    mem_wem  = '0;
    if (fire) begin
      mem_we   = req_we[gnt_idx];
      mem_addr = req_addr[int'(gnt_idx)*AW +: AW];
      mem_din  = req_din[int'(gnt_idx)*DW +: DW];
      mem_wem  = req_wem[int'(gnt_idx)*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= ST_IDLE;
      owner    <= '0;
      ptr      <= PW'(N - 1);
      lock_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (fire) ptr <= gnt_idx;
      case (state)
        ST_IDLE: begin
          if (fire && req_lock[gnt_idx]) begin
            state    <= ST_LOCKED;
            owner    <= gnt_idx;
            lock_cnt <= LOCK_CW'(1);
          end
        end
        ST_LOCKED: begin
          if (!req_valid[owner]) begin
            state    <= ST_IDLE;
            lock_cnt <= '0;
          end else if (fire) begin
            // The final allowed beat releases the lock even if req_lock stays high.
            if (!req_lock[owner] || lock_cnt == LOCK_CW'(LOCK_LIMIT - 1)) begin
              state    <= ST_IDLE;
              lock_cnt <= '0;
            end else begin
              lock_cnt <= lock_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      // NOTE: the response pipe is control state, so it is reset to drop in-flight reads.
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
    end else begin
      rd_pipe[0] <= gnt & ~req_we;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign rsp_valid = rd_pipe[RD_LAT-1];
  assign rsp_dout  = (|rsp_valid) ? mem_dout : '0;

endmodule

// File: tb/tb_memory_sp_arb.sv
// Bench for memory_sp_arb: stands in for the single-port memory, keeps a
// behavioural arbitration/memory model, and adds directed literal checks.
module tb_memory_sp_arb;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int N     = 2;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            nreset;
  logic [N-1:0]    req_valid, req_we, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_din, req_wem;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_dout;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_din, mem_wem, mem_dout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memory_sp_arb #(.DW(DW), .DEPTH(DEPTH), .N(N), .AW(AW)) dut (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_din(req_din), .req_wem(req_wem),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_dout(rsp_dout),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_wem(mem_wem), .mem_dout(mem_dout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bit_at(input logic [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  // Single-port memory stand-in driven by the arbiter's memory command.
  logic [DW-1:0] tb_mem [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= (tb_mem[mem_addr] & ~mem_wem) | (mem_din & mem_wem);
      else        mem_dout <= tb_mem[mem_addr];
    end
  end

  // Behavioural model: round-robin from the last granted index, 16-beat lock cap,
  // read data returned one cycle after the grant.
  logic [DW-1:0] model_mem [DEPTH];
  int            m_last   = N - 1;
  bit            m_locked = 1'b0;
  int            m_owner  = 0;
  int            m_beats  = 0;
  logic [N-1:0]  m_rsp_v  = '0;
  logic [DW-1:0] m_rsp_d  = '0;

  always @(negedge clk) begin : compare
    int            g;
    int            a;
    logic [N-1:0]  exp_ready;
    logic [DW-1:0] d, w;
    if (!nreset) begin
      check("rst_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_dout", rsp_dout, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      m_last = N - 1; m_locked = 1'b0; m_beats = 0; m_rsp_v = '0;
    end else begin
      g = -1;
      if (m_locked) begin
        if (bit_at(req_valid, m_owner)) g = m_owner;
      end else begin
        for (int k = 1; k <= N; k++)
          if (g < 0 && bit_at(req_valid, (m_last + k) % N)) g = (m_last + k) % N;
      end
      exp_ready = '0;
      if (g >= 0) exp_ready = N'(1) << g;
      check("ready", req_ready, exp_ready);
      check("mem_en", mem_en, g >= 0);
      if (g >= 0) begin
        a = int'(AW'(req_addr >> (g * AW)));
        d = DW'(req_din >> (g * DW));
        w = DW'(req_wem >> (g * DW));
        check("mem_we", mem_we, bit_at(req_we, g));
        check("mem_addr", mem_addr, a);
        if (bit_at(req_we, g)) begin
          check("mem_din", mem_din, d);
          check("mem_wem", mem_wem, w);
        end
      end else begin
        check("idle_mem_we", mem_we, 0);
        check("idle_mem_wem", mem_wem, 0);
      end
      check("rsp_valid", rsp_valid, m_rsp_v);
      if (|m_rsp_v) check("rsp_dout", rsp_dout, m_rsp_d);

      m_rsp_v = '0;
      if (g >= 0) begin
        if (bit_at(req_we, g)) model_mem[a] = (model_mem[a] & ~w) | (d & w);
        else begin
          m_rsp_v = N'(1) << g;
          m_rsp_d = model_mem[a];
        end
      end
      if (m_locked && !bit_at(req_valid, m_owner)) m_locked = 1'b0;
      if (g >= 0) begin
        m_last = g;
        if (m_locked) begin
          m_beats++;
          if (!bit_at(req_lock, g) || m_beats >= 16) m_locked = 1'b0;
        end else if (bit_at(req_lock, g)) begin
          m_locked = 1'b1;
          m_owner  = g;
          m_beats  = 1;
        end
      end
    end
  end

  task automatic set_in(input logic [N-1:0] v, input logic [N-1:0] we, input logic [N-1:0] lock,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [DW-1:0] w0, input logic [DW-1:0] w1);
    req_valid = v;
    req_we    = we;
    req_lock  = lock;
    req_addr  = {a1, a0};
    req_din   = {d1, d0};
    req_wem   = {w1, w0};
  endtask

  // Drive one cycle's inputs just after the edge, then settle mid-cycle.
  task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] we, input logic [N-1:0] lock,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                     input logic [DW-1:0] w0, input logic [DW-1:0] w1);
    @(posedge clk);
    #1;
    set_in(v, we, lock, a0, a1, d0, d1, w0, w1);
    #3;
  endtask

  localparam logic [DW-1:0] ONES = '1;

  int r0_run;

  initial begin
    nreset = 1'b0;
    set_in(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, '0, '0, '0, '0);
    mem_dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]    = 32'h1000_0000 + DW'(i);
      model_mem[i] = 32'h1000_0000 + DW'(i);
    end

    // Requests during reset must not be accepted.
    cyc(2'b11, 2'b00, 2'b00, 5'd1, 5'd2, '0, '0, '0, '0);
    check("lit_rst_gate", req_ready, 2'b00);
    cyc(2'b11, 2'b00, 2'b00, 5'd1, 5'd2, '0, '0, '0, '0);

    // Release with both requesters reading: r0 then r1.
    @(posedge clk);
    #1;
    nreset = 1'b1;
    set_in(2'b11, 2'b00, 2'b00, 5'd1, 5'd2, '0, '0, '0, '0);
    #3;
    check("lit_first_grant", req_ready, 2'b01);
    check("lit_first_addr", mem_addr, 5'd1);
    cyc(2'b11, 2'b00, 2'b00, 5'd1, 5'd2, '0, '0, '0, '0);
    check("lit_second_grant", req_ready, 2'b10);
    check("lit_rsp0_valid", rsp_valid, 2'b01);
    check("lit_rsp0_dout", rsp_dout, 32'h1000_0001);
    cyc(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, '0, '0, '0, '0);
    check("lit_rsp1_valid", rsp_valid, 2'b10);
    check("lit_rsp1_dout", rsp_dout, 32'h1000_0002);

    // r0 writes, r1 reads the same word back.
    cyc(2'b01, 2'b01, 2'b00, 5'd5, 5'd0, 32'hDEAD_BEEF, '0, ONES, '0);
    check("lit_wr_we", mem_we, 1'b1);
    check("lit_wr_din", mem_din, 32'hDEAD_BEEF);
    cyc(2'b10, 2'b00, 2'b00, 5'd0, 5'd5, '0, '0, '0, '0);
    check("lit_rd_grant", req_ready, 2'b10);
    cyc(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, '0, '0, '0, '0);
    check("lit_wr_rd_valid", rsp_valid, 2'b10);
    check("lit_wr_rd_dout", rsp_dout, 32'hDEAD_BEEF);

    // Partial write mask keeps the upper half.
    cyc(2'b10, 2'b10, 2'b00, 5'd0, 5'd7, '0, 32'hAAAA_5555, '0, 32'h0000_FFFF);
    cyc(2'b01, 2'b00, 2'b00, 5'd7, 5'd0, '0, '0, '0, '0);
    cyc(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, '0, '0, '0, '0);
    check("lit_mask_dout", rsp_dout, 32'h1000_5555);

    // Read, write, read of one address in consecutive cycles stays in order.
    cyc(2'b01, 2'b00, 2'b00, 5'd9, 5'd0, '0, '0, '0, '0);
    cyc(2'b10, 2'b10, 2'b00, 5'd0, 5'd9, '0, 32'h1234_5678, '0, ONES);
    check("lit_order_old", rsp_dout, 32'h1000_0009);
    cyc(2'b01, 2'b00, 2'b00, 5'd9, 5'd0, '0, '0, '0, '0);
    cyc(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, '0, '0, '0, '0);
    check("lit_order_new", rsp_dout, 32'h1234_5678);

    // Idle cycles leave the pointer alone: r0 granted last, so r1 wins next.
    cyc(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, '0, '0, '0, '0);
    cyc(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, '0, '0, '0, '0);
    cyc(2'b11, 2'b00, 2'b00, 5'd0, 5'd1, '0, '0, '0, '0);
    check("lit_idle_ptr", req_ready, 2'b10);

    // r0 locks for 20 beats against a continuously valid r1.
    r0_run = 0;
    for (int k = 0; k <= 20; k++) begin
      cyc(2'b11, 2'b00, 2'b01, AW'(k), 5'd31, '0, '0, '0, '0);
      if (k < 16 && req_ready == 2'b01) r0_run++;
      if (k == 16) check("lit_lock_cap_r1", req_ready, 2'b10);
      if (k == 17) check("lit_lock_cap_r0", req_ready, 2'b01);
    end
    check("lit_lock_run", r0_run, 16);
    cyc(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, '0, '0, '0, '0);

    // r1 three-beat locked write burst, lock dropped on the third beat.
    cyc(2'b11, 2'b10, 2'b10, 5'd0, 5'd20, '0, 32'hCAFE_0020, '0, ONES);
    check("lit_burst_b1", req_ready, 2'b10);
    cyc(2'b11, 2'b10, 2'b10, 5'd0, 5'd21, '0, 32'hCAFE_0021, '0, ONES);
    check("lit_burst_b2", req_ready, 2'b10);
    cyc(2'b11, 2'b10, 2'b00, 5'd0, 5'd22, '0, 32'hCAFE_0022, '0, ONES);
    check("lit_burst_b3", req_ready, 2'b10);
    cyc(2'b11, 2'b00, 2'b00, 5'd20, 5'd0, '0, '0, '0, '0);
    check("lit_burst_after", req_ready, 2'b01);
    cyc(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, '0, '0, '0, '0);
    check("lit_burst_data", rsp_dout, 32'hCAFE_0020);

    // Reset the cycle after a granted read: the response is dropped.
    cyc(2'b01, 2'b00, 2'b00, 5'd3, 5'd0, '0, '0, '0, '0);
    check("lit_pre_rst_grant", req_ready, 2'b01);
    @(posedge clk);
    #1;
    nreset = 1'b0;
    #3;
    check("lit_rst_rsp_valid", rsp_valid, 2'b00);
    check("lit_rst_rsp_dout", rsp_dout, 32'h0);
    check("lit_rst_mem_en", mem_en, 1'b0);
    cyc(2'b01, 2'b00, 2'b00, 5'd3, 5'd0, '0, '0, '0, '0);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    set_in(2'b11, 2'b00, 2'b00, 5'd4, 5'd6, '0, '0, '0, '0);
    #3;
    check("lit_post_rst_grant", req_ready, 2'b01);
    check("lit_post_rst_no_rsp", rsp_valid, 2'b00);
    cyc(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, '0, '0, '0, '0);
    check("lit_post_rst_dout", rsp_dout, 32'h1000_0004);
    cyc(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, '0, '0, '0, '0);
    cyc(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, '0, '0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
